emergency_preempt: RTL and testbench

//  Conditions the raw emergency-vehicle sensor for the intersection lights.

---
 rtl/emergency_preempt.sv | 131 +++++++++++++
 tb/tb_emergency_preempt.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt.sv
// Siren sensor conditioning: 2-flop sync, debounce, one-cycle preemption pulses.
// Optional saturating pulse counter on evt_count when EMERGENCY_COUNT_EN is defined.
module emergency_preempt #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_CYCLES = 18,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       siren_raw,
   input  logic       enable,
   output logic       emergency,
   output logic       busy,
   output logic [1:0] state_dbg
`ifdef EMERGENCY_COUNT_EN
   ,
   output logic [7:0] evt_count
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DEBOUNCE = 2'b01,
      FIRE     = 2'b10,
      COOLDOWN = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             s1;
   logic             s2;

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= siren_raw;
         s2 <= s1;
      end
   end

   // emergency/busy are decoded from the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         emergency <= 1'b0;
         busy      <= 1'b0;
      end else if (!enable) begin
         state     <= IDLE;
         cnt       <= '0;
         emergency <= 1'b0;
         busy      <= 1'b0;
      end else begin
         emergency <= 1'b0;
         unique case (state)
            IDLE: begin
               if (s2) begin
                  state <= DEBOUNCE;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            DEBOUNCE: begin
               if (!s2) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == DB_LAST) begin
                  state     <= FIRE;
                  cnt       <= '0;
                  emergency <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIRE: begin
               state <= COOLDOWN;
               cnt   <= '0;
               busy  <= 1'b1;
            end
            COOLDOWN: begin
               if (cnt == CD_LAST) begin
                  cnt <= '0;
                  if (s2) begin
                     state     <= FIRE;
                     emergency <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef EMERGENCY_COUNT_EN
   logic db_done;
   logic cd_done;
   logic fire_next;

   assign db_done   = (state == DEBOUNCE) && s2 && (cnt == DB_LAST);
   assign cd_done   = (state == COOLDOWN) && s2 && (cnt == CD_LAST);
   assign fire_next = enable && (db_done || cd_done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_count <= 8'h00;
      end else if (fire_next && (evt_count != 8'hFF)) begin
         evt_count <= evt_count + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed bench for emergency_preempt: latency, repeat spacing, glitch,
// enable/reset override; a second fast-cooldown instance covers saturation.
module tb_emergency_preempt;

   logic       clk;
   logic       rst;
   logic       siren_raw;
   logic       enable;
   logic       emergency;
   logic       busy;
   logic [1:0] state_dbg;
   logic       f_emergency;
   logic       f_busy;
   logic [1:0] f_state_dbg;
`ifdef EMERGENCY_COUNT_EN
   logic [7:0] evt_count;
   logic [7:0] f_evt_count;
`endif

   int checks   = 0;
   int failures = 0;

   emergency_preempt u_dut (
      .clk       (clk),
      .rst       (rst),
      .siren_raw (siren_raw),
      .enable    (enable),
      .emergency (emergency),
      .busy      (busy),
      .state_dbg (state_dbg)
`ifdef EMERGENCY_COUNT_EN
      ,
      .evt_count (evt_count)
`endif
   );

   emergency_preempt #(
      .DEBOUNCE_CYCLES (4),
      .COOLDOWN_CYCLES (1),
      .CNT_W           (5)
   ) u_fast (
      .clk       (clk),
      .rst       (rst),
      .siren_raw (siren_raw),
      .enable    (enable),
      .emergency (f_emergency),
      .busy      (f_busy),
      .state_dbg (f_state_dbg)
`ifdef EMERGENCY_COUNT_EN
      ,
      .evt_count (f_evt_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // expected {emergency,busy,state} for a single pulse, siren dropped early
   function automatic logic [3:0] exp_single(input int k);
      logic [1:0] st;
      if (k < 3)       st = 2'b00;
      else if (k < 7)  st = 2'b01;
      else if (k == 7) st = 2'b10;
      else if (k < 26) st = 2'b11;
      else             st = 2'b00;
      return {st == 2'b10, st != 2'b00, st};
   endfunction

   int np;
   int nf;

   initial begin
      rst       = 1'b1;
      siren_raw = 1'b0;
      enable    = 1'b1;
      tick();
      chk("reset_outs", {28'd0, emergency, busy, state_dbg}, 32'd0);
      tick();
      rst = 1'b0;

      // quiet sensor
      np = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if ({emergency, busy, state_dbg} != 4'b0) np++;
      end
      chk("idle_quiet", np, 0);

      // single pulse, siren held 10 cycles
      siren_raw = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         chk($sformatf("single_k%0d", k),
             {28'd0, emergency, busy, state_dbg}, {28'd0, exp_single(k)});
         if (k == 10) siren_raw = 1'b0;
      end

      // held siren: pulses at 7, 26, 45
      pulse_rst();
      siren_raw = 1'b1;
      np = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (emergency) begin
            np++;
            chk($sformatf("held_pulse_k%0d", k), k,
                (np == 1) ? 7 : (np == 2) ? 26 : 45);
         end
      end
      chk("held_npulse", np, 3);
`ifdef EMERGENCY_COUNT_EN
      chk("held_evt", evt_count, 3);
`endif
      siren_raw = 1'b0;
      repeat (10) tick();
      chk("held_idle", {30'd0, busy, emergency}, 0);
      chk("held_state", state_dbg, 2'b00);

      // glitch of 3 synced cycles
      siren_raw = 1'b1;
      np = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 3) siren_raw = 1'b0;
         if (emergency) np++;
         if (k == 5) chk("glitch_deb", state_dbg, 2'b01);
         if (k == 6) chk("glitch_idle", state_dbg, 2'b00);
      end
      chk("glitch_nopulse", np, 0);

      // enable dropped in the FIRE cycle
      siren_raw = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("en_pre_k%0d", k), emergency, k == 7);
      end
      chk("en_fire_state", state_dbg, 2'b10);
      enable = 1'b0;
      tick();
      chk("en_off_emerg", emergency, 1'b0);
      chk("en_off_state", {30'd0, state_dbg}, 0);
      repeat (3) tick();
      chk("en_off_hold", {28'd0, emergency, busy, state_dbg}, 0);
      enable = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         chk($sformatf("rearm_j%0d", j), emergency, j == 5);
         if (j == 6) chk("rearm_cool", state_dbg, 2'b11);
      end

      // async reset mid-cooldown
      rst = 1'b1;
      #1;
      chk("rst_async", {28'd0, emergency, busy, state_dbg}, 0);
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("post_rst_k%0d", k), emergency, k == 7);
         if (k == 3) chk("post_rst_deb", state_dbg, 2'b01);
      end
`ifdef EMERGENCY_COUNT_EN
      chk("post_rst_evt", evt_count, 1);
`endif

      // long hold: fast instance fires every 2 cycles after edge 7
      pulse_rst();
      siren_raw = 1'b1;
      np = 0;
      nf = 0;
      for (int k = 1; k <= 530; k++) begin
         tick();
         if (emergency) np++;
         if (f_emergency) nf++;
      end
      chk("long_main_n", np, 28);
      chk("long_fast_n", nf, 262);
`ifdef EMERGENCY_COUNT_EN
      chk("long_main_evt", evt_count, 28);
      chk("long_fast_sat", f_evt_count, 8'hFF);
`endif
      siren_raw = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
